// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, constants and the sequential adder's FSM state type.
package fp32_pkg;

   localparam int unsigned EXP_W  = 8;
   localparam int unsigned FRAC_W = 23;
   localparam int unsigned SIG_W  = 24;
   localparam int unsigned GRS_W  = 3;

   localparam int unsigned EXP_BIAS = 127;
   localparam logic [7:0]  EXP_MAX  = 8'hFF;
   localparam logic [31:0] QNAN     = 32'h7FC00000;
   localparam logic [31:0] POS_INF  = 32'h7F800000;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      ADD,
      NORM,
      PACK,
      DONE
   } fpState_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational 28-bit leading-zero counter; an all-zero input yields 28.
module fp_lzc (
   input  logic [27:0] value,
   output logic [4:0]  count
);

   logic found;

   always_comb begin
      count = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < 28; i++) begin
         if (!found) begin
            if (value[27 - i]) begin
               found = 1'b1;
            end else begin
               count = count + 5'd1;
            end
         end
      end
   end

endmodule

// File: rtl/fp_addsub_seq.sv
// Sequential binary32 adder/subtractor, truncating rounding, denormals flushed to zero,
// fixed IDLE-ALIGN-ADD-NORM-PACK-DONE schedule with valid/ready on both sides.
module fp_addsub_seq
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] InputA,
   input  logic [31:0] InputB,
   input  logic        op_sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] OutputRes,
   output logic        exception
);

   localparam int unsigned ALN_W = SIG_W + GRS_W;
   localparam int unsigned SUM_W = ALN_W + 1;

   fpState_t state, nextState;

   logic                    accept;
   logic                    bigSign, smallSign, special;
   logic [EXP_W-1:0]        bigExp, expDiff;
   logic [SIG_W-1:0]        bigSig, smallSig;
   logic [ALN_W-1:0]        alignedSmall;
   logic [SUM_W-1:0]        sumSig;
   logic signed [9:0]       normExp;
   logic [FRAC_W-1:0]       normFrac;
   logic                    normZero;

   logic [EXP_W-1:0]        expA, expB;
   logic [SIG_W-1:0]        sigA, sigB;
   logic                    signB, aBig;

   logic [ALN_W-1:0]        alignExt, alignShifted, alignLost, alignNext;
   logic [SUM_W-1:0]        sumNext;
   logic [4:0]              lzCount, shiftAmt;
   logic signed [9:0]       normExpNext;
   logic [FRAC_W-1:0]       normFracNext;
   logic                    normZeroNext;
   logic [31:0]             packRes;
   logic                    packExc;

   assign accept = in_valid & in_ready;

   // Unpack: exp==0 flushes the significand; ordering compares {exp, sig} magnitudes.
   always_comb begin
      expA  = InputA[30:23];
      expB  = InputB[30:23];
      sigA  = (expA == '0) ? '0 : {1'b1, InputA[FRAC_W-1:0]};
      sigB  = (expB == '0) ? '0 : {1'b1, InputB[FRAC_W-1:0]};
      signB = InputB[31] ^ op_sub;
      aBig  = {expA, sigA} >= {expB, sigB};
   end

   always_comb begin
      alignExt     = {smallSig, {GRS_W{1'b0}}};
      alignShifted = alignExt >> expDiff;
      alignLost    = alignExt & ~({ALN_W{1'b1}} << expDiff);
      if (expDiff >= 8'(ALN_W)) begin
         alignNext = {{(ALN_W-1){1'b0}}, |smallSig};
      end else begin
         alignNext = {alignShifted[ALN_W-1:1], alignShifted[0] | (|alignLost)};
      end
   end

   always_comb begin
      if (bigSign == smallSign) begin
         sumNext = {1'b0, bigSig, {GRS_W{1'b0}}} + {1'b0, alignedSmall};
      end else begin
         sumNext = {1'b0, bigSig, {GRS_W{1'b0}}} - {1'b0, alignedSmall};
      end
   end

   fp_lzc u_lzc (
      .value (sumSig),
      .count (lzCount)
   );

   // Hidden bit lives at sumSig[26]; one leading zero (the carry slot) is the norm.
   always_comb begin
      shiftAmt     = lzCount - 5'd1;
      normZeroNext = 1'b0;
      if (sumSig[SUM_W-1]) begin
         normExpNext  = $signed({2'b00, bigExp}) + 10'sd1;
         normFracNext = FRAC_W'(sumSig >> (GRS_W + 1));
      end else begin
         normExpNext  = $signed({2'b00, bigExp}) - $signed({5'b00000, shiftAmt});
         normFracNext = FRAC_W'((sumSig << shiftAmt) >> GRS_W);
         normZeroNext = (sumSig == '0);
      end
   end

   always_comb begin
      packRes = '0;
      packExc = 1'b0;
      if (special) begin
         packRes = QNAN;
         packExc = 1'b1;
      end else if (normExp >= $signed({2'b00, EXP_MAX})) begin
         packRes = {bigSign, POS_INF[30:0]};
         packExc = 1'b1;
      end else if (normExp <= 10'sd0 || normZero) begin
         packRes = '0;
      end else begin
         packRes = {bigSign, normExp[7:0], normFrac};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_comb begin
      nextState = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) nextState = ALIGN;
         end
         ALIGN: nextState = ADD;
         ADD:   nextState = NORM;
         NORM:  nextState = PACK;
         PACK:  nextState = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         special      <= 1'b0;
         bigSign      <= 1'b0;
         smallSign    <= 1'b0;
         bigExp       <= '0;
         expDiff      <= '0;
         bigSig       <= '0;
         smallSig     <= '0;
         alignedSmall <= '0;
         sumSig       <= '0;
         normExp      <= '0;
         normFrac     <= '0;
         normZero     <= 1'b0;
         OutputRes    <= '0;
         exception    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  special <= (expA == EXP_MAX) || (expB == EXP_MAX);
                  if (aBig) begin
                     bigSign   <= InputA[31];
                     bigExp    <= expA;
                     bigSig    <= sigA;
                     smallSign <= signB;
                     smallSig  <= sigB;
                     expDiff   <= expA - expB;
                  end else begin
                     bigSign   <= signB;
                     bigExp    <= expB;
                     bigSig    <= sigB;
                     smallSign <= InputA[31];
                     smallSig  <= sigA;
                     expDiff   <= expB - expA;
                  end
               end
            end
            ALIGN: alignedSmall <= alignNext;
            ADD:   sumSig <= sumNext;
            NORM: begin
               normExp  <= normExpNext;
               normFrac <= normFracNext;
               normZero <= normZeroNext;
            end
            PACK: begin
               OutputRes <= packRes;
               exception <= packExc;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: directed vectors with hand-derived results.
module tb_fp_addsub_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] InputA = '0;
   logic [31:0] InputB = '0;
   logic        op_sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] OutputRes;
   logic        exception;

   fp_addsub_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .InputA    (InputA),
      .InputB    (InputB),
      .op_sub    (op_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .OutputRes (OutputRes),
      .exception (exception)
   );

   always #5 clk = ~clk;

   int edgeNo = 0;
   always @(posedge clk) edgeNo <= edgeNo + 1;

   typedef struct {
      logic [31:0] res;
      logic        exc;
      int          acceptEdge;
      string       name;
   } expT;

   expT  sb[$];
   int   checks = 0;
   int   fails  = 0;
   logic prevValid = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every cycle in DONE is compared against the scoreboard head; pop on handshake.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         check("output_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            if (!prevValid)
               check({sb[0].name, "_latency"}, 32'(edgeNo - sb[0].acceptEdge), 32'd4);
            check({sb[0].name, "_res"}, OutputRes, sb[0].res);
            check({sb[0].name, "_exc"}, 32'(exception), 32'(sb[0].exc));
            check({sb[0].name, "_in_ready_busy"}, 32'(in_ready), 32'd0);
            if (out_ready) void'(sb.pop_front());
         end
      end
      prevValid = out_valid;
   end

   // Returns one edge after acceptance (+1 time unit), with in_valid dropped.
   task automatic send(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] res, input logic exc, input bit track);
      int waited = 0;
      bit ok = 1'b0;
      InputA   = a;
      InputB   = b;
      op_sub   = sub;
      in_valid = 1'b1;
      while (!ok && waited < 50) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         else waited++;
      end
      if (!ok) begin
         check({name, "_accepted"}, 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      if (track) sb.push_back('{res, exc, edgeNo + 1, name});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      InputA   = $urandom();
      InputB   = $urandom();
      op_sub   = 1'($urandom_range(1, 0));
   endtask

   task automatic drain(input string name);
      int w = 0;
      while (sb.size() != 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      check({name, "_drained"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int w;
      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_res", OutputRes, 32'h0);
      check("reset_exc", 32'(exception), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      send("add_basic",    32'h4799FF04, 32'h47838F88, 1'b0, 32'h480EC746, 1'b0, 1'b1);
      send("sub_basic",    32'h4799FF04, 32'h475DD502, 1'b1, 32'h46AC520C, 1'b0, 1'b1);
      send("add_negb",     32'h4799FF04, 32'hC75DD502, 1'b0, 32'h46AC520C, 1'b0, 1'b1);
      send("mixed_exp",    32'hC6181002, 32'h4424C400, 1'b0, 32'hC60DC3C2, 1'b0, 1'b1);
      send("inf_operand",  32'h7F800000, 32'h41480000, 1'b0, 32'h7FC00000, 1'b1, 1'b1);
      send("nan_operand",  32'hFF853000, 32'h41480000, 1'b0, 32'h7FC00000, 1'b1, 1'b1);
      send("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b1);
      send("cancel",       32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b1);
      send("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b1);
      send("three_m_one",  32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, 1'b1);
      send("zero_operand", 32'h00000000, 32'h41480000, 1'b0, 32'h41480000, 1'b0, 1'b1);
      send("denorm_flush", 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b1);
      send("trunc_tiny",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b1);
      send("sticky_sub",   32'h3F800000, 32'h30800000, 1'b1, 32'h3F7FFFFF, 1'b0, 1'b1);
      drain("vectors");

      // Backpressure: three cycles in DONE with out_ready low.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send("backpressure", 32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 1'b0, 1'b1);
      w = 0;
      while (!out_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("bp_valid_seen", 32'(out_valid), 32'd1);
      repeat (2) @(negedge clk);
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain("backpressure");

      // Reset while in ADD: in-flight operation must vanish.
      @(posedge clk);
      #1;
      send("rst_abort", 32'h4799FF04, 32'h47838F88, 1'b0, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_res", OutputRes, 32'h0);
      check("rst_exc", 32'(exception), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send("post_reset", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b1);
      drain("post_reset");

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, fails);
      $fatal(1);
   end

endmodule
